// File: rtl/mod_n_seq_checker_if.sv
// Count-stream bus for the mod-N sequence checker.
// master drives samples and clear; slave returns lock/error status.
interface mod_n_seq_checker_if #(
  parameter int W     = 2,
  parameter int ERR_W = 8
);
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             clear;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [W-1:0]     expected;
  logic [1:0]       state;

  modport master (
    output in_valid, in_data, clear,
    input  locked, err_pulse, err_count,
    input  expected, state
  );

  modport slave (
    input  in_valid, in_data, clear,
    output locked, err_pulse, err_count,
    output expected, state
  );
endinterface

// File: rtl/mod_n_seq_checker.sv
// Receive-side checker for mod-N count streams.
// Locks onto 0..N-1 wrap sequence, flags and counts breaks.
module mod_n_seq_checker #(
  parameter int N        = 3,
  parameter int W        = 2,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input logic clk,
  input logic rstn,
  mod_n_seq_checker_if.slave bus
);
  localparam int RW = $clog2(LOCK_CNT + 1);
  localparam logic [1:0] HUNT = 2'd0;
  localparam logic [1:0] ACQ  = 2'd1;
  localparam logic [1:0] LOCK = 2'd2;

  logic [1:0]       st, st_n;
  logic [RW-1:0]    run, run_n;
  logic [W-1:0]     exp_q, exp_n;
  logic             ep_q, ep_n;
  logic [ERR_W-1:0] ec_q, ec_n;
  logic             lk_q;
  logic             inr, hit, brk;
  logic [1:0]       seed_st;

  function automatic logic [W-1:0] nxt(
    input logic [W-1:0] v
  );
    return (v == W'(N - 1)) ? '0 : v + 1'b1;
  endfunction

  assign inr = {1'b0, bus.in_data} < (W+1)'(N);
  assign hit = inr && (bus.in_data == exp_q);
  assign seed_st = (LOCK_CNT == 1) ? LOCK : ACQ;

  // state register: sequence tracking state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st    <= HUNT;
      run   <= '0;
      exp_q <= '0;
    end else begin
      st    <= st_n;
      run   <= run_n;
      exp_q <= exp_n;
    end
  end

  // next-state: hunt, acquire, lock and reseed on a break
  always_comb begin
    st_n  = st;
    run_n = run;
    exp_n = exp_q;
    brk   = 1'b0;
    if (bus.clear) begin
      st_n  = HUNT;
      run_n = '0;
      exp_n = '0;
    end else if (bus.in_valid) begin
      case (st)
        HUNT: begin
          if (inr) begin
            exp_n = nxt(bus.in_data);
            run_n = RW'(1);
            st_n  = seed_st;
          end
        end
        ACQ, LOCK: begin
          if (hit) begin
            exp_n = nxt(bus.in_data);
            if (st == ACQ) begin
              run_n = run + RW'(1);
              if (run + RW'(1) == RW'(LOCK_CNT))
                st_n = LOCK;
            end
          end else begin
            brk = (st == LOCK);
            if (inr) begin
              exp_n = nxt(bus.in_data);
              run_n = RW'(1);
              st_n  = seed_st;
            end else begin
              run_n = '0;
              st_n  = HUNT;
            end
          end
        end
        default: begin
          st_n  = HUNT;
          run_n = '0;
        end
      endcase
    end
  end

  // output next values: break pulse and saturating count
  always_comb begin
    ep_n = brk;
    ec_n = ec_q;
    if (bus.clear)
      ec_n = '0;
    else if (brk && (ec_q != '1))
      ec_n = ec_q + 1'b1;
  end

  // output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ep_q <= 1'b0;
      ec_q <= '0;
      lk_q <= 1'b0;
    end else begin
      ep_q <= ep_n;
      ec_q <= ec_n;
      lk_q <= (st_n == LOCK);
    end
  end

  assign bus.state     = st;
  assign bus.expected  = exp_q;
  assign bus.locked    = lk_q;
  assign bus.err_pulse = ep_q;
  assign bus.err_count = ec_q;
endmodule
